img_stream_src: RTL and testbench
=================================

// Module: img_stream_src
// PURPOSE
//  Image pixel source: reads an IMG_W x IMG_H 8-bit greyscale frame from a
//  synchronous-read pixel memory in raster order and drives it onto bus_out
//  with a valid/ready handshake.
//  Sits at the front of the image pipeline, feeding the processing chain
//  whose bus_out the result bench dumps each clock.
// PARAMETERS
//  IMG_W   64  pixels per line (>=2)
//  IMG_H   64  lines per frame (>=2)
//  ADDR_W  12  memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  GAP     4   blanking cycles between lines (only with LINE_GAP_EN; >=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       synchronous reset, active-low
//  start      in   1       1-cycle pulse: begin frame (ignored unless IDLE/DONE)
//  mem_rd     out  1       memory read enable
//  mem_addr   out  ADDR_W  memory read address (row*IMG_W+col)
//  mem_data   in   8       read data, valid exactly 1 cycle after mem_rd
//  bus_out    out  8       pixel data
//  bus_valid  out  1       bus_out holds a pixel
//  bus_ready  in   1       downstream accepts; transfer = valid & ready
//  sof        out  1       qualifies first pixel of frame (with bus_valid)
//  eol        out  1       qualifies last pixel of a line
//  eof        out  1       qualifies last pixel of frame
//  busy       out  1       high from accepted start until last transfer
//  done       out  1       1-cycle pulse the cycle after the eof transfer
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all outputs 0, FSM->IDLE, counters 0, output
//    buffer flushed, in-flight read discarded. Reset mid-frame aborts frame;
//    no done pulse.
//  - FSM: IDLE -start-> RUN; RUN -last pixel of line fetched, not last line->
//    GAP (if LINE_GAP_EN) else stays RUN; GAP -GAP cycles-> RUN;
//    RUN -last pixel of frame fetched-> DRAIN; DRAIN -eof transfer-> DONE;
//    DONE -next cycle-> IDLE (done=1 while in DONE). start in DONE is
//    accepted as in IDLE.
//  - Fetch counters col (0..IMG_W-1), row (0..IMG_H-1); col wraps to 0 and
//    row increments on col==IMG_W-1; address computed from counters, no
//    multiplier on the critical path (running address register, +1 per fetch).
//  - Output buffer: 2-entry FIFO holding {pixel,sof,eol,eof}. A read is issued
//    only if (entries + reads_in_flight) < 2, so no data is ever lost under
//    backpressure. Head drives bus_out/flags; pops on valid&ready.
//  - bus_out/flags stable while bus_valid & !bus_ready (AXI-style hold).
//  - Latency: start at cycle 0 -> mem_rd at cycle 1 -> bus_valid at cycle 3
//    (read data registered into buffer). With ready held high: one pixel per
//    cycle, no bubbles within a line.
//  - Simultaneous push and pop on a full buffer: allowed, count unchanged.
//  - start while busy: ignored.
//  - sof/eol/eof are 0 whenever bus_valid is 0.
// CONFIGURATION
//  LINE_GAP_EN defined: after fetching each line's last pixel (except the
//    frame's last), no reads for GAP cycles (GAP state); output side still
//    drains. Models horizontal blanking for line-buffer consumers.
//  LINE_GAP_EN undefined: GAP state and counter not built; lines back-to-back,
//    frame of W*H pixels transfers in W*H cycles under continuous ready.
// TESTING
//  1 reset: rst=0 two cycles mid-frame -> all outputs 0, FSM IDLE, no done.
//  2 IMG_W=4,IMG_H=2, mem[i]=i, ready=1, start -> bus_out 0..7 on
//    consecutive cycles from cycle 3; sof@0, eol@3,7, eof@7; done next cycle.
//  3 ready toggling 1,0,0,1 pseudo-randomly -> every pixel exactly once, in
//    order, data/flags held while stalled; mem_rd never with 2 entries+flight.
//  4 ready=0 for 20 cycles after start -> exactly 2 reads issued, bus_out=0
//    held; on release sequence resumes 1..7 with no loss.
//  5 LINE_GAP_EN, GAP=4, W=4,H=2, ready=1 -> 4 bubble cycles between pixels
//    3 and 4; undefined -> none.
//  6 start pulsed during busy and in DONE -> first ignored, second starts new
//    frame with sof on pixel 0.

Source files
------------

// File: rtl/img_stream_src.sv
// Raster-order greyscale pixel source: reads a frame from sync-read memory onto a valid/ready bus.
// Optional LINE_GAP_EN inserts GAP idle fetch cycles after every line except the last.
module img_stream_src #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12,
   parameter int GAP    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        bus_out,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
`ifdef LINE_GAP_EN
      S_GAP,
`endif
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic [ADDR_W-1:0] addr_q;
   logic              fl_q;
   logic [2:0]        flf_q;
   logic [10:0]       buf_q [2];
   logic              wp_q, rp_q;
   logic [1:0]        cnt_q;
`ifdef LINE_GAP_EN
   localparam int GW = $clog2(GAP + 1);
   logic [GW-1:0]     gap_q;
`endif

   logic        pop, push, last_col, last_row, accept;
   logic [2:0]  occ;
   logic [10:0] head;

   assign head      = buf_q[rp_q];
   assign bus_valid = (cnt_q != 2'd0);
   assign pop       = bus_valid & bus_ready;
   assign push      = fl_q;
   assign last_col  = (col_q == CW'(IMG_W - 1));
   assign last_row  = (row_q == RW'(IMG_H - 1));
   // Slot freed by this cycle's pop counts, so a full-rate stream has no bubbles.
   assign occ       = {1'b0, cnt_q} + {2'b0, fl_q} - {2'b0, pop};
   assign mem_rd    = (state_q == S_RUN) && (occ < 3'd2);
   assign mem_addr  = addr_q;
   assign bus_out   = bus_valid ? head[10:3] : 8'd0;
   assign sof       = bus_valid & head[2];
   assign eol       = bus_valid & head[1];
   assign eof       = bus_valid & head[0];
   assign done      = (state_q == S_DONE);
   assign accept    = start & ((state_q == S_IDLE) | (state_q == S_DONE));
`ifdef LINE_GAP_EN
   assign busy = (state_q == S_RUN) | (state_q == S_GAP) | (state_q == S_DRAIN);
`else
   assign busy = (state_q == S_RUN) | (state_q == S_DRAIN);
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN: begin
            if (mem_rd && last_col) begin
               if (last_row) state_d = S_DRAIN;
`ifdef LINE_GAP_EN
               else          state_d = S_GAP;
`endif
            end
         end
`ifdef LINE_GAP_EN
         S_GAP:   if (gap_q == GW'(GAP - 1)) state_d = S_RUN;
`endif
         S_DRAIN: if (pop && head[0]) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         addr_q   <= '0;
         fl_q     <= 1'b0;
         flf_q    <= 3'b0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         wp_q     <= 1'b0;
         rp_q     <= 1'b0;
         cnt_q    <= 2'd0;
`ifdef LINE_GAP_EN
         gap_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
         end else if (mem_rd) begin
            addr_q <= addr_q + 1'b1;
            if (last_col) begin
               col_q <= '0;
               row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         // Flags ride alongside the read so they land with the data.
         fl_q  <= mem_rd;
         flf_q <= {(row_q == '0) && (col_q == '0), last_col, last_col & last_row};
         if (push) begin
            buf_q[wp_q] <= {mem_data, flf_q};
            wp_q        <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
`ifdef LINE_GAP_EN
         gap_q <= (state_q == S_GAP) ? gap_q + 1'b1 : '0;
`endif
      end
   end

endmodule

// File: tb/tb_img_stream_src.sv
// Bench for img_stream_src: 4x2 frame, mem[i]=i, cycle table plus stall/reset/restart sequences.
module tb_img_stream_src;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 3;
`ifdef LINE_GAP_EN
   localparam int G = 4;
`else
   localparam int G = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          ready = 1'b1;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data = 8'd0;
   logic [7:0]    bus_out;
   logic          bus_valid, sof, eol, eof, busy, done;
   logic [7:0]    mem [8];

   int errors = 0;
   int checks = 0;

   img_stream_src #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .GAP(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .bus_out(bus_out), .bus_valid(bus_valid), .bus_ready(ready),
      .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      if (mem_rd) mem_data <= mem[mem_addr];

   typedef struct {
      int cyc;
      bit rd;
      int addr;
      bit v;
      int d;
      bit s, l, f, b, dn;
   } vec_t;

   vec_t tbl[$];

   task automatic add(int cyc, bit rd, int addr, bit v, int d,
                      bit s, bit l, bit f, bit b, bit dn);
      vec_t r;
      r.cyc = cyc; r.rd = rd; r.addr = addr; r.v = v; r.d = d;
      r.s = s; r.l = l; r.f = f; r.b = b; r.dn = dn;
      tbl.push_back(r);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n, t3, t4, cyc, issued, xfers;
      bit seen, stall;
      logic [7:0] pd;

      for (int i = 0; i < 8; i++) mem[i] = 8'(i);

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("reset_outputs", {mem_rd, mem_addr, bus_out, bus_valid, sof, eol, eof, busy, done}, 0);
      tick();
      rst = 1'b1;

      // Cycle-accurate frame with ready held high
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      add(2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      add(3, 1, 2, 1, 0, 1, 0, 0, 1, 0);
      add(4, 1, 3, 1, 1, 0, 0, 0, 1, 0);
`ifdef LINE_GAP_EN
      add(5, 0, 0, 1, 2, 0, 0, 0, 1, 0);
      add(6, 0, 0, 1, 3, 0, 1, 0, 1, 0);
      add(7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add(8, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add(9, 1, 4, 0, 0, 0, 0, 0, 1, 0);
      add(10, 1, 5, 0, 0, 0, 0, 0, 1, 0);
      add(11, 1, 6, 1, 4, 0, 0, 0, 1, 0);
      add(12, 1, 7, 1, 5, 0, 0, 0, 1, 0);
      add(13, 0, 0, 1, 6, 0, 0, 0, 1, 0);
      add(14, 0, 0, 1, 7, 0, 1, 1, 1, 0);
      add(15, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(16, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
      add(5, 1, 4, 1, 2, 0, 0, 0, 1, 0);
      add(6, 1, 5, 1, 3, 0, 1, 0, 1, 0);
      add(7, 1, 6, 1, 4, 0, 0, 0, 1, 0);
      add(8, 1, 7, 1, 5, 0, 0, 0, 1, 0);
      add(9, 0, 0, 1, 6, 0, 0, 0, 1, 0);
      add(10, 0, 0, 1, 7, 0, 1, 1, 1, 0);
      add(11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
      ready = 1'b1;
      k = 0;
      for (int c = 0; c <= tbl[tbl.size()-1].cyc; c++) begin
         start = (c == 0);
         @(negedge clk);
         if (k < tbl.size() && tbl[k].cyc == c) begin
            chk($sformatf("t2_rd_c%0d", c), mem_rd, tbl[k].rd);
            if (tbl[k].rd) chk($sformatf("t2_addr_c%0d", c), mem_addr, tbl[k].addr);
            chk($sformatf("t2_valid_c%0d", c), bus_valid, tbl[k].v);
            if (tbl[k].v) chk($sformatf("t2_data_c%0d", c), bus_out, tbl[k].d);
            chk($sformatf("t2_flags_c%0d", c), {sof, eol, eof}, {tbl[k].s, tbl[k].l, tbl[k].f});
            chk($sformatf("t2_busy_c%0d", c), busy, tbl[k].b);
            chk($sformatf("t2_done_c%0d", c), done, tbl[k].dn);
            k++;
         end
         tick();
      end
      start = 1'b0;

      // Random backpressure: order, hold while stalled, occupancy bound
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; issued = 0; xfers = 0; seen = 0; stall = 0; pd = 0;
      for (int c = 0; c < 300 && !seen; c++) begin
         ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (mem_rd) issued++;
         if (bus_valid) begin
            chk("t3_data", bus_out, n);
            chk("t3_flags", {sof, eol, eof}, {n == 0, (n % W) == W - 1, n == W * H - 1});
            if (stall) chk("t3_hold", bus_out, pd);
         end
         if (bus_valid && ready) begin
            xfers++;
            n++;
         end
         if (mem_rd) chk("t3_occupancy", (issued - xfers) <= 2, 1);
         stall = bus_valid & ~ready;
         pd = bus_out;
         if (done) seen = 1;
         tick();
      end
      chk("t3_done_seen", seen, 1);
      chk("t3_xfers", xfers, W * H);

      // Long stall right after start
      ready = 1'b0;
      start = 1'b1;
      issued = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_rd) issued++;
         if (c >= 3) begin
            chk("t4_hold_valid", bus_valid, 1);
            chk("t4_hold_data", bus_out, 0);
         end
         tick();
         start = 1'b0;
      end
      chk("t4_reads", issued, 2);
      ready = 1'b1;
      n = 0; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (bus_valid) begin
            chk("t4_data", bus_out, n);
            n++;
         end
         if (done) seen = 1;
         tick();
      end
      chk("t4_count", n, W * H);
      chk("t4_done_seen", seen, 1);

      // start while busy is ignored; start in DONE relaunches
      start = 1'b1;
      n = 0; k = 0; seen = 0; t3 = 0; t4 = 0; cyc = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
         start = (c == 0) || (c == 5);
         @(negedge clk);
         if (bus_valid) begin
            if (sof) k++;
            if (n == 3) t3 = c;
            if (n == 4) t4 = c;
            n++;
         end
         if (done) begin
            seen = 1;
            start = 1'b1;
         end
         tick();
      end
      chk("t6_sof_count", k, 1);
      chk("t6_count", n, W * H);
      chk("t6_line_gap", t4 - t3, 1 + G);
      chk("t6_done_seen", seen, 1);
      start = 1'b0;
      @(negedge clk);
      chk("t6_restart_busy", busy, 1);
      chk("t6_restart_rd", {mem_rd, mem_addr}, {1'b1, 3'd0});
      tick();
      tick();
      @(negedge clk);
      chk("t6_restart_first", {bus_valid, sof, bus_out}, {1'b1, 1'b1, 8'd0});

      // Reset mid-frame aborts with no done pulse
      tick();
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("t1_rst_outputs_a", {mem_rd, mem_addr, bus_out, bus_valid, sof, eol, eof, busy, done}, 0);
      tick();
      @(negedge clk);
      chk("t1_rst_outputs_b", {mem_rd, mem_addr, bus_out, bus_valid, sof, eol, eof, busy, done}, 0);
      tick();
      rst = 1'b1;
      seen = 0;
      k = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done) seen = 1;
         if (bus_valid || busy || mem_rd) k++;
         tick();
      end
      chk("t1_no_done", seen, 0);
      chk("t1_idle_after", k, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
